memory_access_unit: RTL

//  MEM stage of the 5-stage pipeline. Consumes the m_* controls from the EX/MEM register.

---
 rtl/memory_access_unit_if.sv | 20 ++
 rtl/memory_access_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface memory_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_access_unit.sv
// MEM pipeline stage: word/byte loads and stores over a req/ack data bus,
// stalling upstream while an access is outstanding.
module memory_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        m_mem_read,
    input  logic                        m_mem_write,
    input  logic                        m_mem_byte,
    input  logic                        m_reg_write,
    input  logic                        m_mem_to_reg,
    input  logic [31:0]                 m_alu_result,
    input  logic [31:0]                 m_store_data,
    memory_access_unit_if.master        dmem,
    output logic                        mem_stall,
    output logic                        mem_fault,
    output logic                        w_reg_write,
    output logic                        w_mem_to_reg,
    output logic [31:0]                 w_alu_result,
    output logic [31:0]                 w_mem_data
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             fault_q, fault_d;
    logic             w_reg_write_q, w_reg_write_d;
    logic             w_mem_to_reg_q, w_mem_to_reg_d;
    logic [31:0]      w_alu_result_q, w_alu_result_d;
    logic [31:0]      w_mem_data_q, w_mem_data_d;

    logic             access;
    logic             legal;
    logic [1:0]       lane;
    logic             timeout_hit;
    logic [31:0]      rdata_shifted;

    // Next-state, bus and MEM/WB payload logic.
    always_comb begin
        access        = m_mem_read | m_mem_write;
        legal         = (m_mem_read ^ m_mem_write) &
                        (m_mem_byte | (m_alu_result[1:0] == 2'b00));
        lane          = m_alu_result[1:0];
        timeout_hit   = TIMEOUT_EN && (cnt_q == CNT_LAST);
        rdata_shifted = dmem.dmem_rdata >> {lane, 3'b000};

        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        fault_d        = 1'b0;
        w_reg_write_d  = m_reg_write;
        w_mem_to_reg_d = m_mem_to_reg;
        w_alu_result_d = m_alu_result;
        w_mem_data_d   = 32'h0;
        mem_stall      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (access && !legal) begin
                    fault_d        = 1'b1;
                    w_reg_write_d  = 1'b0;
                    w_mem_to_reg_d = 1'b0;
                end else if (access) begin
                    mem_stall     = 1'b1;
                    state_d       = S_BUSY;
                    cnt_d         = '0;
                    req_d         = 1'b1;
                    we_d          = m_mem_write;
                    addr_d        = {m_alu_result[31:2], 2'b00};
                    w_reg_write_d = 1'b0;
                    if (m_mem_write && m_mem_byte) begin
                        be_d    = 4'b0001 << lane;
                        wdata_d = {4{m_store_data[7:0]}};
                    end else begin
                        be_d    = 4'b1111;
                        wdata_d = m_store_data;
                    end
                end
            end
            S_BUSY: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem.dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        w_mem_data_d = m_mem_byte ? {24'h0, rdata_shifted[7:0]}
                                                  : dmem.dmem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d       = S_IDLE;
                    req_d         = 1'b0;
                    fault_d       = 1'b1;
                    w_reg_write_d = 1'b0;
                end else begin
                    mem_stall     = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                    w_reg_write_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 32'h0;
            be_q           <= 4'h0;
            wdata_q        <= 32'h0;
            fault_q        <= 1'b0;
            w_reg_write_q  <= 1'b0;
            w_mem_to_reg_q <= 1'b0;
            w_alu_result_q <= 32'h0;
            w_mem_data_q   <= 32'h0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            fault_q        <= fault_d;
            w_reg_write_q  <= w_reg_write_d;
            w_mem_to_reg_q <= w_mem_to_reg_d;
            w_alu_result_q <= w_alu_result_d;
            w_mem_data_q   <= w_mem_data_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign mem_fault       = fault_q;
    assign w_reg_write     = w_reg_write_q;
    assign w_mem_to_reg    = w_mem_to_reg_q;
    assign w_alu_result    = w_alu_result_q;
    assign w_mem_data      = w_mem_data_q;

endmodule
